// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by alu_seq and its multiply/divide unit.
package alu_pkg;
  localparam int OPCODE_LENGTH = 5;
  typedef enum logic [OPCODE_LENGTH-1:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_XOR   = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_SLT   = 5'b00111,
    OP_EQ    = 5'b01000,
    OP_SRA   = 5'b01001,
    OP_SLTU  = 5'b01010,
    OP_MUL   = 5'b10000,
    OP_MULH  = 5'b10001,
    OP_MULHU = 5'b10010,
    OP_DIV   = 5'b10011,
    OP_DIVU  = 5'b10100,
    OP_REM   = 5'b10101,
    OP_REMU  = 5'b10110
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier and restoring divider, one bit per cycle,
// operating on magnitudes with a final sign fix; division corner cases are resolved combinationally.
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_pkg::alu_op_e op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             byp,
  output logic [W-1:0]     byp_res,
  output logic             done,
  output logic [W-1:0]     res
);
  import alu_pkg::*;
  localparam int CW = $clog2(W) + 1;
  logic sgn, sa, sb, is_div, dq, ovf, ge;
  logic [W-1:0] ma, mb, hi_r, m_q, m_d;
  logic [W:0] sh, diff, acc;
  logic [2*W-1:0] p_q, p_d, p_n, p_f;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d;
  alu_op_e op_q, op_d;
  always_comb begin
    sgn = op inside {OP_MULH, OP_DIV, OP_REM};
    sa = sgn && a[W-1];
    sb = sgn && b[W-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    ovf = (op inside {OP_DIV, OP_REM}) && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    byp = is_div && (b == '0 || ovf);
    byp_res = (b == '0) ? ((op inside {OP_DIV, OP_DIVU}) ? '1 : a) : ((op == OP_DIV) ? a : '0);
    dq = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    // divide: p holds {remainder, dividend/quotient}; multiply: p holds {partial, multiplier}
    sh = p_q[2*W-1:W-1];
    diff = sh - {1'b0, m_q};
    ge = sh >= {1'b0, m_q};
    acc = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_n = dq ? {ge ? diff[W-1:0] : sh[W-1:0], p_q[W-2:0], ge} : {acc, p_q[W-1:1]};
    p_f = neg_q ? -p_n : p_n;
    hi_r = neg_q ? -p_n[2*W-1:W] : p_n[2*W-1:W];
    res = (op_q inside {OP_MULH, OP_MULHU}) ? p_f[2*W-1:W] :
          (op_q inside {OP_REM, OP_REMU}) ? hi_r : p_f[W-1:0];
    done = cnt_q == CW'(1);
    p_d = p_q;
    m_d = m_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    op_d = op_q;
    if (start) begin
      p_d = {{W{1'b0}}, is_div ? ma : mb};
      m_d = is_div ? mb : ma;
      cnt_d = CW'(W);
      neg_d = (op == OP_REM) ? sa : sa ^ sb;
      op_d = op;
    end else if (cnt_q != '0) begin
      p_d = p_n;
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      op_q <= OP_AND;
    end else begin
      p_q <= p_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      op_q <= op_d;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RISC-V ALU with valid/ready handshakes on request and result.
// Define ALU_SEQ_MULDIV_EN to add the iterative RV32M multiply/divide unit.
module alu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = alu_pkg::OPCODE_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);
  import alu_pkg::*;
  localparam int SW = $clog2(DATA_WIDTH);
  alu_state_e st_q, st_d;
  alu_op_e op;
  logic [DATA_WIDTH-1:0] base, acc_res, fin_res, res_d, res_q;
  logic acc, go_busy, fin, zero_d, zero_q;
  logic [SW-1:0] sh;
  assign op = alu_op_e'(Operation);
  assign sh = SrcB[SW-1:0];
  assign acc = in_valid && st_q == IDLE;
  assign in_ready = st_q == IDLE;
  assign out_valid = st_q == DONE;
  assign ALUResult = res_q;
  assign Zero = zero_q;
  always_comb begin
    case (op)
      OP_AND:  base = SrcA & SrcB;
      OP_OR:   base = SrcA | SrcB;
      OP_ADD:  base = SrcA + SrcB;
      OP_XOR:  base = SrcA ^ SrcB;
      OP_SLL:  base = SrcA << sh;
      OP_SRL:  base = SrcA >> sh;
      OP_SUB:  base = SrcA - SrcB;
      OP_SLT:  base = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_EQ:   base = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SRA:  base = $signed(SrcA) >>> sh;
      OP_SLTU: base = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
      default: base = '0;
    endcase
  end
`ifdef ALU_SEQ_MULDIV_EN
  logic is_m, md_byp, md_done;
  logic [DATA_WIDTH-1:0] md_byp_res, md_res;
  assign is_m = op inside {[OP_MUL:OP_REMU]};
  assign go_busy = acc && is_m && !md_byp;
  alu_muldiv_iter #(.W(DATA_WIDTH)) u_md (
    .clk(clk), .rst_n(rst_n), .start(go_busy), .op(op), .a(SrcA), .b(SrcB),
    .byp(md_byp), .byp_res(md_byp_res), .done(md_done), .res(md_res)
  );
  assign acc_res = is_m ? md_byp_res : base;
  assign fin = md_done;
  assign fin_res = md_res;
`else
  assign go_busy = 1'b0;
  assign acc_res = base;
  assign fin = 1'b0;
  assign fin_res = '0;
`endif
  always_comb begin
    st_d = st_q;
    res_d = res_q;
    if (acc) begin
      st_d = go_busy ? BUSY : DONE;
      res_d = go_busy ? res_q : acc_res;
    end else if (st_q == BUSY && fin) begin
      st_d = DONE;
      res_d = fin_res;
    end else if (st_q == DONE && out_ready) begin
      st_d = IDLE;
    end
    zero_d = res_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      res_q <= '0;
      zero_q <= 1'b1;
    end else begin
      st_q <= st_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, stall/reset sequences and random ops against a reference model.
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, Zero;
  logic [31:0] SrcA = '0, SrcB = '0, ALUResult;
  logic [4:0] Operation = '0;
  int checks = 0, errors = 0;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );
  typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat; } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!MD && op >= 5'd16) return '0;
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd3:  return a ^ b;
      5'd4:  return a << b[4:0];
      5'd5:  return a >> b[4:0];
      5'd6:  return a - b;
      5'd7:  return {31'd0, sa < sb};
      5'd8:  return {31'd0, a == b};
      5'd9:  return 32'(sa >>> b[4:0]);
      5'd10: return {31'd0, a < b};
      5'd16: return 32'(sa * sb);
      5'd17: return 32'((sa * sb) >>> 32);
      5'd18: return 32'((ua * ub) >> 32);
      5'd19: return (b == 0) ? '1 : 32'(sa / sb);
      5'd20: return (b == 0) ? '1 : a / b;
      5'd21: return (b == 0) ? a : 32'(sa % sb);
      5'd22: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!MD || op < 5'd16 || op > 5'd22) return 1;
    if (op >= 5'd19 && (b == 0 || ((op == 5'd19 || op == 5'd21) && a == 32'h80000000 && b == '1))) return 1;
    return 33;
  endfunction
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] r, output logic z, output int lat);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; Operation = 5'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = ALUResult;
    z = Zero;
    @(posedge clk); #1;
    chk("consumed", {31'd0, out_valid}, 32'd0);
  endtask
  initial begin
    logic [31:0] r, e, a, b;
    logic z;
    int lat;
    logic [4:0] ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                            5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd31};
    tbl.push_back('{5'd2,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1});
    tbl.push_back('{5'd7,  32'hFFFFFFFF, 32'd1,        32'd1,        1});
    tbl.push_back('{5'd10, 32'hFFFFFFFF, 32'd1,        32'd0,        1});
    tbl.push_back('{5'd9,  32'h80000000, 32'd33,       32'hC0000000, 1});
    tbl.push_back('{5'd6,  32'd5,        32'd7,        32'hFFFFFFFE, 1});
    tbl.push_back('{5'd8,  32'd5,        32'd5,        32'd1,        1});
    tbl.push_back('{5'd4,  32'd1,        32'd31,       32'h80000000, 1});
    tbl.push_back('{5'd15, 32'd9,        32'd9,        32'd0,        1});
`ifdef ALU_SEQ_MULDIV_EN
    tbl.push_back('{5'd16, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33});
    tbl.push_back('{5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    tbl.push_back('{5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33});
    tbl.push_back('{5'd19, 32'd7,        32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{5'd21, 32'd7,        32'd0,        32'd7,        1});
    tbl.push_back('{5'd19, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    tbl.push_back('{5'd19, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    tbl.push_back('{5'd21, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
`else
    tbl.push_back('{5'd16, 32'hFFFFFFFD, 32'd7,        32'd0,        1});
    tbl.push_back('{5'd19, 32'd7,        32'd0,        32'd0,        1});
`endif
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat);
      chk($sformatf("tbl%0d_res", i), r, tbl[i].exp);
      chk($sformatf("tbl%0d_zero", i), {31'd0, z}, {31'd0, tbl[i].exp == 0});
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end
    // result held while the consumer stalls; a second request must be ignored
    @(negedge clk);
    in_valid = 1'b1; Operation = 5'd3; SrcA = 32'hF0F0F0F0; SrcB = 32'h0F0F0F0F; out_ready = 1'b0;
    @(posedge clk); #1;
    Operation = 5'd2; SrcA = 32'd1; SrcB = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_res", ALUResult, 32'hFFFFFFFF);
      chk("stall_zero", {31'd0, Zero}, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'd0, out_valid}, 32'd0);
    // asynchronous reset in the middle of a DIVU
    @(negedge clk);
    in_valid = 1'b1; Operation = 5'd20; SrcA = 32'd1000; SrcB = 32'd7; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", ALUResult, 32'd0);
    chk("midrst_zero", {31'd0, Zero}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run(5'd20, 32'd1000, 32'd7, r, z, lat);
    chk("after_rst_res", r, ref_res(5'd20, 32'd1000, 32'd7));
    chk("after_rst_lat", lat, ref_lat(5'd20, 32'd1000, 32'd7));
    for (int n = 0; n < 150; n++) begin
      logic [4:0] op;
      int mode;
      op = ops[$urandom_range(0, 19)];
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = '0;
      if (mode == 1) begin a = 32'h80000000; b = '1; end
      if (mode == 2) begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 40) - 20; end
      run(op, a, b, r, z, lat);
      e = ref_res(op, a, b);
      chk($sformatf("rnd op=%0d a=%h b=%h res", op, a, b), r, e);
      chk($sformatf("rnd op=%0d zero", op), {31'd0, z}, {31'd0, e == 0});
      chk($sformatf("rnd op=%0d lat", op), lat, ref_lat(op, a, b));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
